// File: rtl/intersection_fsm_if.sv
// Signal bundle between the intersection controller and its wrapper:
// demand/emergency inputs in, light codes and status out.
interface intersection_fsm_if #(
  parameter int NUM_ROADS = 3,
  parameter int RW        = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
);
  logic                   ena;
  logic [NUM_ROADS-1:0]   req;
  logic                   ped_req;
  logic                   emg_valid;
  logic [RW-1:0]          emg_road;
  logic [2*NUM_ROADS-1:0] light;
  logic                   walk;
  logic                   emg_active;
  logic [RW-1:0]          cur_road;
  logic                   ped_pending;

  modport master (
    output ena, req, ped_req, emg_valid, emg_road,
    input  light, walk, emg_active, cur_road, ped_pending
  );

  modport slave (
    input  ena, req, ped_req, emg_valid, emg_road,
    output light, walk, emg_active, cur_road, ped_pending
  );
endinterface

// File: rtl/intersection_fsm.sv
// N-road traffic light controller: round-robin green service, latched walk
// phase and level-sensitive emergency preemption, all outputs from flops.
module intersection_fsm #(
  parameter int NUM_ROADS  = 3,
  parameter int TW         = 8,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int PED_CYC    = 5,
  localparam int RW        = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  intersection_fsm_if.slave     bus
);

  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK} state_t;

  localparam logic [TW-1:0] G_LOAD = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] Y_LOAD = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] A_LOAD = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] P_LOAD = TW'(PED_CYC - 1);
  localparam logic [RW:0]   NR_EXT = (RW+1)'(NUM_ROADS);

  state_t         state_reg, state_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [RW-1:0]  cur_road_reg, cur_road_next;
  logic           emg_active_reg, emg_active_next;
  logic           ped_pending_reg, ped_pending_next;

  logic                 emg_ok;
  logic                 emg_here;
  logic                 other_req;
  logic                 rr_found;
  logic [RW-1:0]        rr_road;
  logic [RW:0]          cand_sum  [NUM_ROADS];
  logic [RW-1:0]        cand_road [NUM_ROADS];
  logic [NUM_ROADS-1:0] cand_hit;

  // Out-of-range emergency road codes are treated as no emergency.
  assign emg_ok    = bus.emg_valid && ({1'b0, bus.emg_road} < NR_EXT);
  assign emg_here  = emg_ok && (bus.emg_road == cur_road_reg);
  assign other_req = |(bus.req & ~((NUM_ROADS)'(1) << cur_road_reg));

  // Candidate gi is road (cur_road + gi + 1) mod NUM_ROADS, so cur_road comes last.
  for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_cand
    assign cand_sum[gi]  = {1'b0, cur_road_reg} + (RW+1)'(gi + 1);
    assign cand_road[gi] = (cand_sum[gi] >= NR_EXT) ? RW'(cand_sum[gi] - NR_EXT)
                                                    : RW'(cand_sum[gi]);
    assign cand_hit[gi]  = bus.req[cand_road[gi]];
  end

  always_comb begin
    rr_found = 1'b0;
    rr_road  = cur_road_reg;
    for (int k = NUM_ROADS - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        rr_found = 1'b1;
        rr_road  = cand_road[k];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    cur_road_next    = cur_road_reg;
    emg_active_next  = emg_active_reg;
    ped_pending_next = ped_pending_reg | bus.ped_req;

    case (state_reg)
      S_ALLRED: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else if (emg_ok) begin
          state_next      = S_GREEN;
          cur_road_next   = bus.emg_road;
          emg_active_next = 1'b1;
          timer_next      = G_LOAD;
        end else if (ped_pending_reg) begin
          state_next       = S_WALK;
          timer_next       = P_LOAD;
          ped_pending_next = 1'b0;
        end else if (rr_found) begin
          state_next      = S_GREEN;
          cur_road_next   = rr_road;
          emg_active_next = 1'b0;
          timer_next      = G_LOAD;
        end
      end

      S_GREEN: begin
        if (emg_active_reg) begin
          // Emergency green ignores the timer; it lasts exactly as long as the claim.
          if (!emg_here) begin
            state_next      = S_YELLOW;
            timer_next      = Y_LOAD;
            emg_active_next = 1'b0;
          end
        end else if (emg_ok && !emg_here) begin
          state_next = S_YELLOW;
          timer_next = Y_LOAD;
        end else if (emg_here) begin
          emg_active_next = 1'b1;
        end else if (timer_reg == '0) begin
          if (other_req || ped_pending_reg) begin
            state_next = S_YELLOW;
            timer_next = Y_LOAD;
          end else begin
            timer_next = G_LOAD;
          end
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      S_YELLOW, S_WALK: begin
        if (timer_reg == '0) begin
          state_next = S_ALLRED;
          timer_next = A_LOAD;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end

      default: begin
        state_next = S_ALLRED;
        timer_next = A_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= S_ALLRED;
      timer_reg       <= A_LOAD;
      cur_road_reg    <= '0;
      emg_active_reg  <= 1'b0;
      ped_pending_reg <= 1'b0;
    end else if (bus.ena) begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      cur_road_reg    <= cur_road_next;
      emg_active_reg  <= emg_active_next;
      ped_pending_reg <= ped_pending_next;
    end
  end

  for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_light
    assign bus.light[2*gi+1:2*gi] =
      (cur_road_reg != RW'(gi))  ? 2'b00 :
      (state_reg == S_GREEN)     ? 2'b10 :
      (state_reg == S_YELLOW)    ? 2'b01 : 2'b00;
  end

  assign bus.walk        = (state_reg == S_WALK);
  assign bus.emg_active  = emg_active_reg;
  assign bus.cur_road    = cur_road_reg;
  assign bus.ped_pending = ped_pending_reg;

endmodule

// File: tb/tb_intersection_fsm.sv
// Directed bench for intersection_fsm with default parameters (3 roads,
// green 8, yellow 3, all-red 2, walk 5); edge numbers in comments count from reset release.
module tb_intersection_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  intersection_fsm_if #(.NUM_ROADS(3), .RW(2)) bus ();

  intersection_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.req       = 3'b000;
    bus.ped_req   = 1'b0;
    bus.emg_valid = 1'b0;
    bus.emg_road  = 2'd0;
    step(2);
    check("rst_light", 32'(bus.light), 32'h0);
    check("rst_walk", 32'(bus.walk), 32'h0);
    check("rst_emg", 32'(bus.emg_active), 32'h0);
    check("rst_cur", 32'(bus.cur_road), 32'h0);
    check("rst_ped", 32'(bus.ped_pending), 32'h0);

    // Road1 demand: two all-red cycles, then road1 green and green rest.
    rst_n   = 1'b1;
    bus.req = 3'b010;
    step(1);                                          // e1
    check("allred_1", 32'(bus.light), 32'h0);
    step(1);                                          // e2: green road1, timer 7
    check("green_r1", 32'(bus.light), 32'b001000);
    check("cur_r1", 32'(bus.cur_road), 32'd1);
    step(10);                                         // e12
    check("green_rest", 32'(bus.light), 32'b001000);

    // Demand on roads 0 and 2 at timer 0: round-robin picks road2 next.
    step(5);                                          // e17: timer 0
    bus.req = 3'b101;
    step(1);                                          // e18
    check("yellow_r1", 32'(bus.light), 32'b000100);
    step(2);                                          // e20
    check("yellow_r1_end", 32'(bus.light), 32'b000100);
    step(1);                                          // e21
    check("allred_a", 32'(bus.light), 32'h0);
    step(1);                                          // e22
    check("allred_b", 32'(bus.light), 32'h0);
    step(1);                                          // e23
    check("green_r2", 32'(bus.light), 32'b100000);
    check("cur_r2", 32'(bus.cur_road), 32'd2);
    step(7);                                          // e30
    check("green_r2_last", 32'(bus.light), 32'b100000);
    step(1);                                          // e31
    check("yellow_r2", 32'(bus.light), 32'b010000);
    step(5);                                          // e36
    check("green_r0", 32'(bus.light), 32'b000010);
    check("cur_r0", 32'(bus.cur_road), 32'd0);

    // Pedestrian pulse during road0 green.
    bus.req     = 3'b000;
    bus.ped_req = 1'b1;
    step(1);                                          // e37
    bus.ped_req = 1'b0;
    check("ped_latched", 32'(bus.ped_pending), 32'h1);
    step(6);                                          // e43
    check("green_r0_hold", 32'(bus.light), 32'b000010);
    step(1);                                          // e44
    check("yellow_r0", 32'(bus.light), 32'b000001);
    step(4);                                          // e48
    check("allred_preped", 32'(bus.light), 32'h0);
    check("ped_still", 32'(bus.ped_pending), 32'h1);
    step(1);                                          // e49
    check("walk_on", 32'(bus.walk), 32'h1);
    check("walk_light", 32'(bus.light), 32'h0);
    check("ped_cleared", 32'(bus.ped_pending), 32'h0);
    step(4);                                          // e53
    check("walk_last", 32'(bus.walk), 32'h1);
    step(1);                                          // e54
    check("walk_off", 32'(bus.walk), 32'h0);

    // Road0 served again (searched last); emergency on road2 at timer 5.
    bus.req = 3'b001;
    step(2);                                          // e56
    check("green_r0_wrap", 32'(bus.light), 32'b000010);
    step(2);                                          // e58: timer 5
    bus.req       = 3'b000;
    bus.emg_valid = 1'b1;
    bus.emg_road  = 2'd2;
    step(1);                                          // e59
    check("emg_trunc", 32'(bus.light), 32'b000001);
    step(5);                                          // e64
    check("emg_green", 32'(bus.light), 32'b100000);
    check("emg_active", 32'(bus.emg_active), 32'h1);
    step(5);                                          // e69
    check("emg_hold", 32'(bus.light), 32'b100000);
    bus.emg_valid = 1'b0;
    step(1);                                          // e70
    check("emg_drop", 32'(bus.light), 32'b010000);
    check("emg_clear", 32'(bus.emg_active), 32'h0);

    // Walk with an invalid road code, then a valid emergency that must wait for walk.
    bus.ped_req   = 1'b1;
    bus.emg_valid = 1'b1;
    bus.emg_road  = 2'd3;
    step(1);                                          // e71
    bus.ped_req = 1'b0;
    check("ped_again", 32'(bus.ped_pending), 32'h1);
    step(4);                                          // e75
    check("walk_bad_emg", 32'(bus.walk), 32'h1);
    check("no_emg_bad", 32'(bus.emg_active), 32'h0);
    bus.emg_road = 2'd1;
    step(4);                                          // e79
    check("walk_not_abort", 32'(bus.walk), 32'h1);
    step(1);                                          // e80
    check("walk_done", 32'(bus.walk), 32'h0);
    step(2);                                          // e82
    check("emg_after_walk", 32'(bus.light), 32'b001000);
    check("emg_after_flag", 32'(bus.emg_active), 32'h1);

    // Freeze mid-yellow for 10 cycles, then finish the remaining yellow cycle.
    bus.emg_valid = 1'b0;
    step(2);                                          // e84: yellow timer 1
    check("yellow_pre_freeze", 32'(bus.light), 32'b000100);
    bus.ena     = 1'b0;
    bus.ped_req = 1'b1;
    step(10);
    check("freeze_light", 32'(bus.light), 32'b000100);
    check("freeze_ped", 32'(bus.ped_pending), 32'h0);
    bus.ena     = 1'b1;
    bus.ped_req = 1'b0;
    step(1);
    check("resume_yellow", 32'(bus.light), 32'b000100);
    step(1);
    check("resume_allred", 32'(bus.light), 32'h0);

    // Reset mid-green drops the latched pedestrian request.
    bus.req = 3'b100;
    step(2);
    check("green_r2b", 32'(bus.light), 32'b100000);
    bus.ped_req = 1'b1;
    step(1);
    bus.ped_req = 1'b0;
    check("ped_pre_rst", 32'(bus.ped_pending), 32'h1);
    rst_n = 1'b0;
    step(1);
    check("midrst_light", 32'(bus.light), 32'h0);
    check("midrst_cur", 32'(bus.cur_road), 32'h0);
    check("midrst_ped", 32'(bus.ped_pending), 32'h0);
    check("midrst_walk", 32'(bus.walk), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
